pll_hdmi_seq: RTL and testbench

//   Power-up and recovery sequencer for the HDMI PLL (74.25 MHz in; pixel and 5x TMDS clocks out).
//   - Drives the PLL RESET pin and watches LOCK.
//   - Holds the video/TMDS pipeline in reset until lock has been stable for a qualified time.
//   - Re-sequences the PLL on lock loss, retries a bounded number of times, then flags failure.
//   - Runs on the free-running reference clock, never on a PLL output.

---
 rtl/pll_hdmi_seq.sv | 169 ++++++++++++++++
 tb/tb_pll_hdmi_seq.sv | 282 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/pll_hdmi_seq.sv
// HDMI PLL power-up and recovery sequencer. Runs on the free-running reference
// clock so it keeps sequencing while the PLL outputs are absent or unstable.
module pll_hdmi_seq #(
  parameter int RESET_CYCLES  = 16,
  parameter int LOCK_TIMEOUT  = 65536,
  parameter int STABLE_CYCLES = 1024,
  parameter int MAX_RETRY     = 3
) (
  input  logic       i_clk,
  input  logic       i_resetn,
  input  logic       i_pll_lock,
  input  logic       i_restart,
  output logic       o_pll_reset,
  output logic       o_video_rstn,
  output logic       o_pll_ready,
  output logic       o_pll_fail,
  output logic [3:0] o_retry_cnt,
  output logic [7:0] o_lock_loss_cnt
);

  localparam int MAX_RS   = (RESET_CYCLES > STABLE_CYCLES) ? RESET_CYCLES : STABLE_CYCLES;
  localparam int MAX_LOAD = (LOCK_TIMEOUT > MAX_RS) ? LOCK_TIMEOUT : MAX_RS;
  localparam int CNT_W    = (MAX_LOAD > 1) ? $clog2(MAX_LOAD) : 1;

  localparam logic [CNT_W-1:0] CNT_ZERO  = CNT_W'(0);
  localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);
  localparam logic [CNT_W-1:0] RST_LOAD  = CNT_W'(RESET_CYCLES - 1);
  localparam logic [CNT_W-1:0] WAIT_LOAD = CNT_W'(LOCK_TIMEOUT - 1);
  localparam logic [CNT_W-1:0] STAB_LOAD = CNT_W'(STABLE_CYCLES - 1);
  localparam logic [3:0]       RETRY_LIM = 4'(MAX_RETRY);

  typedef enum logic [2:0] {
    ST_RST  = 3'd0,
    ST_WAIT = 3'd1,
    ST_STAB = 3'd2,
    ST_RUN  = 3'd3,
    ST_FAIL = 3'd4
  } state_t;

  logic             r_lock_meta;
  logic             r_lock_s;
  state_t           r_state;
  logic [CNT_W-1:0] r_cnt;
  logic [3:0]       r_retry;
  logic [7:0]       r_loss;
  logic             r_pll_reset;
  logic             r_video_rstn;
  logic             r_pll_ready;
  logic             r_pll_fail;

  state_t           w_state_nxt;
  logic [CNT_W-1:0] w_cnt_nxt;
  logic [3:0]       w_retry_nxt;
  logic [7:0]       w_loss_nxt;
  logic [3:0]       w_retry_inc;
  logic             w_retry_exhaust;
  logic             w_cnt_zero;

  // Two-flop synchronizer for the asynchronous PLL lock indication
  always_ff @(posedge i_clk or negedge i_resetn) begin
    if (!i_resetn) begin
      r_lock_meta <= 1'b0;
      r_lock_s    <= 1'b0;
    end else begin
      r_lock_meta <= i_pll_lock;
      r_lock_s    <= r_lock_meta;
    end
  end

  assign w_retry_inc     = r_retry + 4'd1;
  assign w_retry_exhaust = (w_retry_inc == RETRY_LIM);
  assign w_cnt_zero      = (r_cnt == CNT_ZERO);

  // Next-state decode; restart overrides every other transition
  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    w_retry_nxt = r_retry;
    w_loss_nxt  = r_loss;
    if (i_restart) begin
      w_state_nxt = ST_RST;
      w_cnt_nxt   = RST_LOAD;
      w_retry_nxt = 4'd0;
    end else begin
      case (r_state)
        ST_RST: begin
          if (w_cnt_zero) begin
            w_state_nxt = ST_WAIT;
            w_cnt_nxt   = WAIT_LOAD;
          end else begin
            w_cnt_nxt = r_cnt - CNT_ONE;
          end
        end
        ST_WAIT: begin
          if (r_lock_s) begin
            w_state_nxt = ST_STAB;
            w_cnt_nxt   = STAB_LOAD;
          end else if (w_cnt_zero) begin
            w_retry_nxt = w_retry_inc;
            w_state_nxt = w_retry_exhaust ? ST_FAIL : ST_RST;
            w_cnt_nxt   = w_retry_exhaust ? CNT_ZERO : RST_LOAD;
          end else begin
            w_cnt_nxt = r_cnt - CNT_ONE;
          end
        end
        ST_STAB: begin
          if (!r_lock_s) begin
            w_retry_nxt = w_retry_inc;
            w_state_nxt = w_retry_exhaust ? ST_FAIL : ST_RST;
            w_cnt_nxt   = w_retry_exhaust ? CNT_ZERO : RST_LOAD;
          end else if (w_cnt_zero) begin
            w_state_nxt = ST_RUN;
            w_cnt_nxt   = CNT_ZERO;
            w_retry_nxt = 4'd0;
          end else begin
            w_cnt_nxt = r_cnt - CNT_ONE;
          end
        end
        ST_RUN: begin
          if (!r_lock_s) begin
            w_state_nxt = ST_RST;
            w_cnt_nxt   = RST_LOAD;
            w_loss_nxt  = (r_loss == 8'hFF) ? 8'hFF : (r_loss + 8'd1);
          end else begin
            w_state_nxt = ST_RUN;
          end
        end
        ST_FAIL: begin
          w_state_nxt = ST_FAIL;
        end
        default: begin
          w_state_nxt = ST_RST;
          w_cnt_nxt   = RST_LOAD;
        end
      endcase
    end
  end

  // State register; outputs are decoded from the next state so they change on the same edge
  always_ff @(posedge i_clk or negedge i_resetn) begin
    if (!i_resetn) begin
      r_state      <= ST_RST;
      r_cnt        <= RST_LOAD;
      r_retry      <= 4'd0;
      r_loss       <= 8'd0;
      r_pll_reset  <= 1'b1;
      r_video_rstn <= 1'b0;
      r_pll_ready  <= 1'b0;
      r_pll_fail   <= 1'b0;
    end else begin
      r_state      <= w_state_nxt;
      r_cnt        <= w_cnt_nxt;
      r_retry      <= w_retry_nxt;
      r_loss       <= w_loss_nxt;
      r_pll_reset  <= (w_state_nxt == ST_RST) || (w_state_nxt == ST_FAIL);
      r_video_rstn <= (w_state_nxt == ST_RUN);
      r_pll_ready  <= (w_state_nxt == ST_RUN);
      r_pll_fail   <= (w_state_nxt == ST_FAIL);
    end
  end

  assign o_pll_reset     = r_pll_reset;
  assign o_video_rstn    = r_video_rstn;
  assign o_pll_ready     = r_pll_ready;
  assign o_pll_fail      = r_pll_fail;
  assign o_retry_cnt     = r_retry;
  assign o_lock_loss_cnt = r_loss;

endmodule

// File: tb/tb_pll_hdmi_seq.sv
// Directed/randomized bench for pll_hdmi_seq with a timestamp-based reference model.
module tb_pll_hdmi_seq;

  localparam int RC = 4;
  localparam int LT = 32;
  localparam int SC = 8;
  localparam int MR = 2;

  localparam int P_RST  = 0;
  localparam int P_WAIT = 1;
  localparam int P_STAB = 2;
  localparam int P_RUN  = 3;
  localparam int P_FAIL = 4;

  logic       clk      = 1'b0;
  logic       resetn   = 1'b1;
  logic       pll_lock = 1'b0;
  logic       restart  = 1'b0;
  logic       o_pll_reset;
  logic       o_video_rstn;
  logic       o_pll_ready;
  logic       o_pll_fail;
  logic [3:0] o_retry_cnt;
  logic [7:0] o_lock_loss_cnt;

  always #5 clk = ~clk;

  pll_hdmi_seq #(
    .RESET_CYCLES (RC),
    .LOCK_TIMEOUT (LT),
    .STABLE_CYCLES(SC),
    .MAX_RETRY    (MR)
  ) dut (
    .i_clk          (clk),
    .i_resetn       (resetn),
    .i_pll_lock     (pll_lock),
    .i_restart      (restart),
    .o_pll_reset    (o_pll_reset),
    .o_video_rstn   (o_video_rstn),
    .o_pll_ready    (o_pll_ready),
    .o_pll_fail     (o_pll_fail),
    .o_retry_cnt    (o_retry_cnt),
    .o_lock_loss_cnt(o_lock_loss_cnt)
  );

  int n_checks = 0;
  int n_pass   = 0;

  // Reference model: phase plus the edge number at which it was entered
  int m_phase;
  int m_enter;
  int m_retry;
  int m_loss;
  int m_n;
  bit m_hist[$];

  task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    n_checks++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
  endtask

  task automatic model_reset();
    m_phase = P_RST;
    m_enter = 0;
    m_retry = 0;
    m_loss  = 0;
    m_n     = 0;
    m_hist.delete();
  endtask

  task automatic model_attempt_failed();
    m_retry++;
    if (m_retry == MR) m_phase = P_FAIL;
    else begin
      m_phase = P_RST;
      m_enter = m_n;
    end
  endtask

  task automatic model_edge(input bit raw, input bit rs);
    bit l;
    m_n++;
    m_hist.push_back(raw);
    // lock as seen by the sequencer: raw value two edges earlier
    l = (m_hist.size() >= 3) ? m_hist[m_hist.size()-3] : 1'b0;
    if (rs) begin
      m_phase = P_RST;
      m_enter = m_n;
      m_retry = 0;
    end else begin
      case (m_phase)
        P_RST:  if (m_n == m_enter + RC) begin m_phase = P_WAIT; m_enter = m_n; end
        P_WAIT: begin
          if (l) begin m_phase = P_STAB; m_enter = m_n; end
          else if (m_n == m_enter + LT) model_attempt_failed();
        end
        P_STAB: begin
          if (!l) model_attempt_failed();
          else if (m_n == m_enter + SC) begin m_phase = P_RUN; m_retry = 0; end
        end
        P_RUN: begin
          if (!l) begin
            m_phase = P_RST;
            m_enter = m_n;
            if (m_loss < 255) m_loss++;
          end
        end
        default: ;
      endcase
    end
  endtask

  task automatic check_outputs();
    check("pll_reset",  {7'd0, o_pll_reset},  {7'd0, (m_phase == P_RST) || (m_phase == P_FAIL)});
    check("video_rstn", {7'd0, o_video_rstn}, {7'd0, (m_phase == P_RUN)});
    check("pll_ready",  {7'd0, o_pll_ready},  {7'd0, (m_phase == P_RUN)});
    check("pll_fail",   {7'd0, o_pll_fail},   {7'd0, (m_phase == P_FAIL)});
    check("retry_cnt",  {4'd0, o_retry_cnt},  8'(m_retry));
    check("lock_loss",  o_lock_loss_cnt,      8'(m_loss));
  endtask

  task automatic check_reset_values(input string tag);
    check({tag, "_pll_reset"},  {7'd0, o_pll_reset},  8'd1);
    check({tag, "_video_rstn"}, {7'd0, o_video_rstn}, 8'd0);
    check({tag, "_pll_ready"},  {7'd0, o_pll_ready},  8'd0);
    check({tag, "_pll_fail"},   {7'd0, o_pll_fail},   8'd0);
    check({tag, "_retry"},      {4'd0, o_retry_cnt},  8'd0);
    check({tag, "_loss"},       o_lock_loss_cnt,      8'd0);
  endtask

  task automatic tick();
    bit raw;
    bit rs;
    raw = pll_lock;
    rs  = restart;
    @(posedge clk);
    model_edge(raw, rs);
    @(negedge clk);
    check_outputs();
  endtask

  task automatic wait_phase(input int ph, input int budget, input string tag, output int took);
    took = 0;
    while (m_phase != ph && took < budget) begin
      tick();
      took++;
    end
    check({tag, "_reached"}, {7'd0, (m_phase == ph)}, 8'd1);
  endtask

  task automatic pulse_restart();
    restart = 1'b1;
    tick();
    restart = 1'b0;
  endtask

  initial begin
    int k;
    int hi;
    int hold;

    // T1 power-up
    #2 resetn = 1'b0;
    #1 check_reset_values("por");
    model_reset();
    repeat (2) @(negedge clk);
    resetn = 1'b1;
    hi = 0;
    while (o_pll_reset && hi < 20) begin
      hi++;
      tick();
    end
    check("t1_rst_len", 8'(hi), 8'(RC));
    repeat (9) tick();
    pll_lock = 1'b1;
    k = 0;
    while (!o_video_rstn && k < 40) begin
      tick();
      k++;
    end
    check("t1_vid_lat", 8'(k), 8'(2 + SC + 1));
    check("t1_ready", {7'd0, o_pll_ready}, 8'd1);
    check("t1_retry", {4'd0, o_retry_cnt}, 8'd0);

    // T2 lock chatter during stabilisation
    pll_lock = 1'b0;
    pulse_restart();
    wait_phase(P_WAIT, 20, "t2_wait", k);
    repeat ($urandom_range(1, 20)) tick();
    pll_lock = 1'b1;
    repeat (5) tick();
    pll_lock = 1'b0;
    tick();
    pll_lock = 1'b1;
    wait_phase(P_RST, 20, "t2_rst", k);
    check("t2_retry1", {4'd0, o_retry_cnt}, 8'd1);
    wait_phase(P_RUN, 100, "t2_run", k);
    check("t2_retry0", {4'd0, o_retry_cnt}, 8'd0);

    // T3 no lock at all
    pll_lock = 1'b0;
    pulse_restart();
    wait_phase(P_FAIL, 200, "t3_fail", k);
    check("t3_fail_time", 8'(k), 8'(MR * (RC + LT)));
    check("t3_retry", {4'd0, o_retry_cnt}, 8'(MR));
    check("t3_pll_reset", {7'd0, o_pll_reset}, 8'd1);
    repeat (20) begin
      pll_lock = 1'($urandom_range(0, 1));
      tick();
    end
    check("t3_parked", {7'd0, o_pll_fail}, 8'd1);

    // T5a restart out of FAIL
    pll_lock = 1'b0;
    pulse_restart();
    check("t5_fail_clr", {7'd0, o_pll_fail}, 8'd0);
    check("t5_retry_clr", {4'd0, o_retry_cnt}, 8'd0);
    repeat ($urandom_range(0, 15)) tick();
    pll_lock = 1'b1;
    wait_phase(P_RUN, 100, "t5_run", k);

    // T4 lock loss in RUN
    repeat ($urandom_range(1, 10)) tick();
    pll_lock = 1'b0;
    k = 0;
    while (o_video_rstn && k < 10) begin
      tick();
      k++;
    end
    check("t4_vid_fall", 8'(k), 8'd3);
    check("t4_loss", o_lock_loss_cnt, 8'd1);
    repeat ($urandom_range(3, 20)) tick();
    pll_lock = 1'b1;
    wait_phase(P_RUN, 100, "t4_run", k);

    // T5b restart coincident with a lock drop seen in RUN
    pll_lock = 1'b0;
    tick();
    tick();
    pulse_restart();
    check("t5_loss_kept", o_lock_loss_cnt, 8'd1);
    check("t5_rst", {7'd0, o_pll_reset}, 8'd1);

    // restart held: reset time counts from the last restart cycle
    pll_lock = 1'b1;
    restart = 1'b1;
    hold = $urandom_range(2, 6);
    repeat (hold) tick();
    restart = 1'b0;
    hi = 0;
    while (o_pll_reset && hi < 20) begin
      tick();
      hi++;
    end
    check("t5_hold_len", 8'(hi), 8'(RC));
    wait_phase(P_RUN, 100, "t5b_run", k);

    // T6 async reset mid-STAB, then lock-loss saturation
    pulse_restart();
    wait_phase(P_STAB, 40, "t6_stab", k);
    repeat (3) tick();
    #2 resetn = 1'b0;
    #1 check_reset_values("t6_async");
    model_reset();
    repeat (2) @(negedge clk);
    resetn = 1'b1;
    for (int i = 0; i < 256; i++) begin
      wait_phase(P_RUN, 60, "t6_run", k);
      repeat ($urandom_range(0, 3)) tick();
      pll_lock = 1'b0;
      repeat (3) tick();
      pll_lock = 1'b1;
    end
    repeat (5) tick();
    check("t6_loss_sat", o_lock_loss_cnt, 8'd255);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
